// File: rtl/fpga_ram_ctrl_pkg.sv
// Shared definitions for the RAM controller: FSM encoding and response buffer depth.
package fpga_ram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  localparam int RSPDEPTH = 2;

endpackage

// File: rtl/fpga_ram.sv
// Single-port synchronous RAM with registered read data (read-first).
module fpga_ram #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 PortAClk,
  input  logic                 WrEn,
  input  logic [ADDRWIDTH-1:0] Addr,
  input  logic [DATAWIDTH-1:0] WrData,
  output logic [DATAWIDTH-1:0] RdData
);

  logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

  always_ff @(posedge PortAClk) begin
    if (WrEn) mem[Addr] <= WrData;
    RdData <= mem[Addr];
  end

endmodule

// File: rtl/fpga_ram_ctrl.sv
// RAM controller: clears the RAM after reset, then serves valid/ready read and
// write requests, buffering read data in a 2-entry response FIFO.
//
// state | meaning
// INIT  | writing zeros to every address, requests blocked
// RUN   | clear finished, requests accepted while buffer credit remains
module fpga_ram_ctrl
  import fpga_ram_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 PortAClk,
  input  logic                 PortAReset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [ADDRWIDTH-1:0] ReqAddr,
  input  logic [DATAWIDTH-1:0] ReqData,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic [DATAWIDTH-1:0] RspData,
  output logic                 InitDone
);

  localparam int MEMDEPTH = 2**ADDRWIDTH;

  ctrl_state_e          state, stateNext;
  logic [ADDRWIDTH-1:0] clearAddr;
  logic                 rdPending;
  logic [1:0]           occupancy;
  logic [DATAWIDTH-1:0] rspBuf [RSPDEPTH];
  logic                 wrPtr, rdPtr;
  logic                 push, pop;
  logic [2:0]           credit;

  logic                 ramWe;
  logic [ADDRWIDTH-1:0] ramAddr;
  logic [DATAWIDTH-1:0] ramWrData;
  logic [DATAWIDTH-1:0] ramRdData;

  always_ff @(posedge PortAClk) begin
    if (PortAReset) state <= INIT;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      INIT:    if (clearAddr == ADDRWIDTH'(MEMDEPTH - 1)) stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = INIT;
    endcase
  end

  // Credit counts buffered plus in-flight reads, minus the entry leaving now.
  assign credit = {1'b0, occupancy} + {2'b00, rdPending} - {2'b00, pop};

  always_comb begin
    ramWe     = 1'b0;
    ramAddr   = ReqAddr;
    ramWrData = ReqData;
    ReqReady  = 1'b0;
    InitDone  = 1'b0;
    case (state)
      INIT: begin
        ramWe     = !PortAReset;
        ramAddr   = clearAddr;
        ramWrData = '0;
      end
      RUN: begin
        InitDone = !PortAReset;
        ReqReady = !PortAReset && (credit < 3'(RSPDEPTH));
        ramWe    = ReqValid && ReqReady && ReqWrite;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PortAClk) begin
    if (PortAReset)         clearAddr <= '0;
    else if (state == INIT) clearAddr <= clearAddr + 1'b1;
  end

  always_ff @(posedge PortAClk) begin
    if (PortAReset) rdPending <= 1'b0;
    else            rdPending <= ReqValid && ReqReady && !ReqWrite;
  end

  assign push     = rdPending;
  assign RspValid = !PortAReset && (occupancy != 2'd0);
  assign pop      = RspValid && RspReady;
  assign RspData  = PortAReset ? '0 : rspBuf[rdPtr];

  always_ff @(posedge PortAClk) begin
    if (PortAReset) begin
      occupancy <= 2'd0;
      wrPtr     <= 1'b0;
      rdPtr     <= 1'b0;
      for (int i = 0; i < RSPDEPTH; i++) rspBuf[i] <= '0;
    end else begin
      if (push) rspBuf[wrPtr] <= ramRdData;
      wrPtr     <= wrPtr ^ push;
      rdPtr     <= rdPtr ^ pop;
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
    end
  end

  fpga_ram #(
    .DATAWIDTH(DATAWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) uRam (
    .PortAClk(PortAClk),
    .WrEn    (ramWe),
    .Addr    (ramAddr),
    .WrData  (ramWrData),
    .RdData  (ramRdData)
  );

endmodule

// File: doc/fpga_ram_ctrl.md
FPGA_RAM_CTRL -- requirements
Module: fpga_ram_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, RAM word width in bits.
REQ-002 SHALL have parameter ADDRWIDTH, default 10, RAM address width; depth MEMDEPTH = 2**ADDRWIDTH.
REQ-003 SHALL have port PortAClk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port PortAReset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ReqValid, input, 1, request present.
REQ-006 SHALL have port ReqReady, output, 1, request accepted this cycle when ReqValid is also high.
REQ-007 SHALL have port ReqWrite, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port ReqAddr, input, ADDRWIDTH, word address.
REQ-009 SHALL have port ReqData, input, DATAWIDTH, write data; ignored for reads.
REQ-010 SHALL have port RspValid, output, 1, read data available.
REQ-011 SHALL have port RspReady, input, 1, consumer takes the response when RspValid is also high.
REQ-012 SHALL have port RspData, output, DATAWIDTH, read data.
REQ-013 SHALL have port InitDone, output, 1, high once the RAM clear sequence has completed.

Function
REQ-014 SHALL have a two-state FSM, INIT and RUN; reset enters INIT with the clear address at 0.
REQ-015 In INIT, SHALL write all-zero data to RAM address clear_addr each cycle, increment clear_addr, and move to RUN after writing MEMDEPTH-1; the clear takes exactly MEMDEPTH cycles.
REQ-016 In INIT, ReqReady and InitDone SHALL be 0; in RUN, InitDone SHALL be 1.
REQ-017 The transfer rule SHALL be: a request transfers when ReqValid && ReqReady; a response transfers (pop) when RspValid && RspReady.
REQ-018 In RUN, ReqReady SHALL be 1 when (occupancy + rd_pending - pop) < 2. occupancy is the response-buffer count (0..2); rd_pending is the read-issued-last-cycle flag. ReqReady depends combinationally on RspReady.
REQ-019 An accepted write SHALL drive the RAM write in the same cycle and produce no response.
REQ-020 An accepted read in cycle N SHALL set rd_pending in N+1. The RAM output SHALL be pushed into the response buffer at the end of N+1, so RspValid is high in N+2 at the earliest.
REQ-021 The response buffer SHALL be a 2-entry FIFO with in-order delivery. RspData SHALL be the head entry and SHALL stay stable while RspValid && !RspReady.
REQ-022 A push and a pop in the same cycle SHALL leave occupancy unchanged; a push SHALL never occur when occupancy is 2 and there is no pop (guaranteed by REQ-018).
REQ-023 A write accepted in cycle N SHALL be visible to a read accepted in N+1 or later.
REQ-024 With RspReady held high, sustained reads SHALL achieve one request per cycle.

Reset
REQ-025 While PortAReset is high, the outputs SHALL be ReqReady=0, RspValid=0, InitDone=0, RspData=0; occupancy, rd_pending and clear_addr SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard buffered and pending reads and restart the full clear sequence; RAM contents before the clear are don't-care.

Structure
REQ-027 SHALL instantiate exactly one fpga_ram (DATAWIDTH, ADDRWIDTH passed through) as the storage sub-module; the RAM port mux selects between the clear path and the request path by FSM state.
REQ-028 SHALL place the FSM state encoding (INIT, RUN) and the response-buffer depth constant (2) in a shared package.

Verification (bench parameters DATAWIDTH=32, ADDRWIDTH=4)
REQ-029 Reset then idle -> InitDone rises exactly 16 cycles after reset release; reads of addresses 0..15 then return 0x00000000.
REQ-030 Write 0xDEADBEEF to address 5 in cycle N, read address 5 in N+1 with RspReady=1 -> RspValid in N+3 with RspData=0xDEADBEEF.
REQ-031 RspReady=1, back-to-back reads of addresses 0..15 after writing data=addr*3 -> ReqReady stays 1 and 16 in-order responses arrive on 16 consecutive cycles.
REQ-032 RspReady=0, issue 4 reads -> exactly 2 accepted, ReqReady=0 and RspData stable; raise RspReady -> 2 responses in order, then remaining reads accepted.
REQ-033 Assert reset while 1 response is buffered and 1 read is pending -> RspValid=0 next cycle, the clear sequence re-runs for 16 cycles, and no stale response appears.
REQ-034 Simultaneous push and pop at occupancy 1 -> occupancy stays 1 and the next RspData equals the newly pushed word.
